// File: rtl/sha1_job_scheduler.sv
// Job FIFO plus dispatcher that feeds a SHA-1 core one descriptor at a time and returns tagged results.
// Optional watchdog in WAIT is built only when SHA1_SCHED_TIMEOUT_EN is defined.
module sha1_job_scheduler #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [31:0]  job_addr,
    input  logic [31:0]  job_size,
    input  logic [3:0]   job_tag,
    output logic         start_hash,
    output logic [31:0]  message_addr,
    output logic [31:0]  message_size,
    input  logic [159:0] hash,
    input  logic         done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [159:0] res_hash,
    output logic [3:0]   res_tag,
    output logic         res_err,
    output logic         busy,
    output logic [15:0]  jobs_done
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

    state_t         state, state_next;
    logic [31:0]    fifo_addr [DEPTH];
    logic [31:0]    fifo_size [DEPTH];
    logic [3:0]     fifo_tag  [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, empty, push, pop, misaligned, capture, timed_out;
    logic [1:0]     phase;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign job_ready  = ~full & ~reset;
    assign push       = job_valid & job_ready;
    assign misaligned = (fifo_addr[rd_ptr][1:0] != 2'b00);

`ifdef SHA1_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`endif

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        timed_out  = 1'b0;
        start_hash = 1'b0;
        res_valid  = (state == RESULT);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = misaligned ? RESULT : START;
                end
            end
            START: begin
                // phase 0 presents the descriptor; phases 1-2 pulse start_hash
                start_hash = (phase != 2'd0);
                if (phase == 2'd2) state_next = WAIT;
            end
            WAIT: begin
                if (done) begin
                    capture    = 1'b1;
                    state_next = RESULT;
                end
`ifdef SHA1_SCHED_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timed_out  = 1'b1;
                    state_next = RESULT;
                end
`endif
            end
            RESULT: begin
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= job_addr;
            fifo_size[wr_ptr] <= job_size;
            fifo_tag[wr_ptr]  <= job_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= '0;
            message_addr <= '0;
            message_size <= '0;
            res_hash     <= '0;
            res_tag      <= '0;
            res_err      <= 1'b0;
            jobs_done    <= '0;
        end else begin
            state <= state_next;
            phase <= (state == START) ? phase + 2'd1 : 2'd0;
            if (pop) begin
                message_addr <= fifo_addr[rd_ptr];
                message_size <= fifo_size[rd_ptr];
                res_tag      <= fifo_tag[rd_ptr];
                res_err      <= misaligned;
                res_hash     <= '0;
            end
            if (capture) begin
                res_hash <= hash;
                res_err  <= 1'b0;
            end
            if (timed_out) begin
                res_hash <= '0;
                res_err  <= 1'b1;
            end
            if (state == RESULT && res_ready) jobs_done <= jobs_done + 16'd1;
        end
    end

`ifdef SHA1_SCHED_TIMEOUT_EN
    // START always precedes WAIT, so holding zero outside WAIT clears the count on entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              wait_cnt <= '0;
        else if (state == WAIT) wait_cnt <= wait_cnt + TW'(1);
        else                    wait_cnt <= '0;
    end
`endif

endmodule

// File: tb/tb_sha1_job_scheduler.sv
// Randomized directed bench for sha1_job_scheduler with a behavioural hash-core and result-queue model.
module tb_sha1_job_scheduler;
    localparam int unsigned DEPTH = 4;
`ifdef SHA1_SCHED_TIMEOUT_EN
    localparam int unsigned LAT_MAIN = 10;
`else
    localparam int unsigned LAT_MAIN = 300;
`endif

    logic         clk, reset, job_valid, job_ready, start_hash, done;
    logic         res_valid, res_ready, res_err, busy;
    logic [31:0]  job_addr, job_size, message_addr, message_size;
    logic [3:0]   job_tag, res_tag;
    logic [159:0] hash, res_hash;
    logic [15:0]  jobs_done;

    sha1_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_addr(job_addr), .job_size(job_size), .job_tag(job_tag),
        .start_hash(start_hash), .message_addr(message_addr), .message_size(message_size),
        .hash(hash), .done(done), .res_valid(res_valid), .res_ready(res_ready),
        .res_hash(res_hash), .res_tag(res_tag), .res_err(res_err),
        .busy(busy), .jobs_done(jobs_done)
    );

    typedef struct {
        logic [159:0] h;
        logic [3:0]   t;
        logic         e;
    } res_t;

    res_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_done = 0;
    int          start_count = 0;
    int unsigned core_lat = 0;
    bit          core_kick = 0;
    logic [31:0] salt;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [159:0] hash_of(input logic [31:0] a, input logic [31:0] s);
        return {a ^ salt, s, a + s, ~s, salt ^ 32'h6745_2301};
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hash core: done drops on start, rises core_lat steps after the last start cycle (0 = stall).
    initial begin
        int unsigned  cnt;
        int           run;
        logic [159:0] cur;
        cnt = 0; run = 0; cur = '0;
        done = 0; hash = '0;
        forever begin
            @(posedge clk);
            #2;
            if (start_hash) begin
                if (run == 0) start_count++;
                run++;
                done = 0;
                cur = hash_of(message_addr, message_size);
                cnt = core_lat;
                core_kick = 0;
            end else begin
                if (run != 0) check("start_len", 160'(run), 160'd2);
                run = 0;
                if (!done) begin
                    if (core_kick) begin
                        done = 1; hash = cur; core_kick = 0;
                    end else if (cnt > 0) begin
                        cnt--;
                        if (cnt == 0) begin done = 1; hash = cur; end
                    end
                end
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] s, input logic [3:0] t);
        res_t r;
        int   w;
        job_valid = 1; job_addr = a; job_size = s; job_tag = t;
        w = 0;
        while (!job_ready && w < 2000) begin @(negedge clk); w++; end
        check("push_ready", job_ready, 1);
        @(negedge clk);
        job_valid = 0;
        r.e = (a[1:0] != 2'b00);
        r.h = r.e ? '0 : hash_of(a, s);
        r.t = t;
        exp_q.push_back(r);
    endtask

    task automatic wait_res(input string tag);
        int w;
        w = 0;
        while (!res_valid && w < 5000) begin @(negedge clk); w++; end
        check(tag, res_valid, 1);
    endtask

    task automatic collect(input string tag, input int unsigned hold);
        res_t e;
        e.h = '0; e.t = '0; e.e = 0;
        wait_res({tag, "_valid"});
        repeat (hold) @(negedge clk);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, "_hash"}, res_hash, e.h);
        check({tag, "_tag"}, res_tag, e.t);
        check({tag, "_err"}, res_err, e.e);
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        exp_done++;
        check({tag, "_jobs_done"}, jobs_done, 16'(exp_done));
        check({tag, "_valid_drop"}, res_valid, 0);
    endtask

    initial begin
        int          s0, aligned, w;
        logic [31:0] a, s;
        salt = $urandom;
        reset = 1; job_valid = 0; job_addr = 0; job_size = 0; job_tag = 0; res_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", job_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_start", start_hash, 0);
        check("rst_done_cnt", jobs_done, 0);
        check("rst_maddr", message_addr, 0);
        reset = 0;
        @(negedge clk);
        check("post_rst_ready", job_ready, 1);

        // single job, minimum latency
        core_lat = LAT_MAIN;
        s0 = start_count;
        push(32'h0, 32'd54, 4'd3);
        check("lat_n", start_hash, 0);
        @(negedge clk); check("lat_n1", start_hash, 0);
        @(negedge clk); check("lat_n2", start_hash, 1);
        check("lat_msize", message_size, 32'd54);
        @(negedge clk); check("lat_n3", start_hash, 1);
        @(negedge clk); check("lat_n4", start_hash, 0);
        check("lat_busy", busy, 1);
        collect("single", 0);
        check("single_starts", 160'(start_count - s0), 160'd1);

        // fill with a stalled core, then hold the first result
        core_lat = 0;
        s0 = start_count;
        for (int i = 0; i < 5; i++) begin
            push($urandom & 32'hFFFF_FFFC, $urandom, 4'(i + 5));
            if (i >= 1) check("ready_occ", job_ready, (i < DEPTH));
        end
        repeat (40) @(negedge clk);
        check("stall_starts", 160'(start_count - s0), 160'd1);
`ifdef SHA1_SCHED_TIMEOUT_EN
        exp_q[0].h = '0;
        exp_q[0].e = 1;
`else
        core_kick = 1;
`endif
        core_lat = 5;
        wait_res("hold_valid");
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k % 10 == 9) begin
                check("hold_valid", res_valid, 1);
                check("hold_hash", res_hash, exp_q[0].h);
                check("hold_tag", res_tag, exp_q[0].t);
                check("hold_nostart", 160'(start_count - s0), 160'd1);
                check("hold_full", job_ready, 0);
            end
        end
        for (int i = 0; i < 5; i++) collect("order", 0);

        // misaligned address: error result, core never started
        s0 = start_count;
        push(32'h6, 32'd100, 4'd9);
        collect("misalign", 0);
        check("misalign_nostart", 160'(start_count - s0), 160'd0);

        // randomized rounds
        s0 = start_count;
        aligned = 0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                a = $urandom;
                if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
                s = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                if (a[1:0] == 2'b00) aligned++;
                core_lat = $urandom_range(1, 12);
                push(a, s, 4'($urandom));
            end
            for (int j = 0; j < 3; j++) collect("rand", $urandom_range(0, 2));
        end
        check("rand_starts", 160'(start_count - s0), 160'(aligned));

        // reset while waiting on the core with jobs queued
        core_lat = 0;
        for (int i = 0; i < 3; i++) push({$urandom_range(1, 255), 2'b00}, 32'd64, 4'(i + 1));
        repeat (8) @(negedge clk);
        check("midrst_busy", busy, 1);
        reset = 1;
        #1;
        check("midrst_busy0", busy, 0);
        check("midrst_ready", job_ready, 0);
        check("midrst_valid", res_valid, 0);
        check("midrst_start", start_hash, 0);
        check("midrst_maddr", message_addr, 0);
        check("midrst_msize", message_size, 0);
        check("midrst_hash", res_hash, 0);
        check("midrst_tag", res_tag, 0);
        check("midrst_err", res_err, 0);
        check("midrst_jobs", jobs_done, 0);
        exp_q.delete();
        exp_done = 0;
        @(negedge clk);
        reset = 0;
        s0 = start_count;
        core_kick = 1; core_lat = 3; res_ready = 1;
        w = 0;
        repeat (60) begin
            @(negedge clk);
            if (res_valid) w++;
        end
        res_ready = 0;
        check("midrst_no_result", 160'(w), 160'd0);
        check("midrst_no_start", 160'(start_count - s0), 160'd0);

        // core never answers
        core_lat = 0;
        push(32'h100, 32'd7, 4'hA);
        w = 0;
        while (!start_hash && w < 100) begin @(negedge clk); w++; end
        while (start_hash && w < 100) begin @(negedge clk); w++; end
        check("to_start_seen", 160'(w < 100), 160'd1);
`ifdef SHA1_SCHED_TIMEOUT_EN
        repeat (15) @(negedge clk);
        check("to_early", res_valid, 0);
        @(negedge clk);
        check("to_fire", res_valid, 1);
        exp_q[0].h = '0;
        exp_q[0].e = 1;
        collect("timeout", 0);
`else
        repeat (200) @(negedge clk);
        check("no_timeout", res_valid, 0);
        core_kick = 1;
        collect("late_done", 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
